// File: rtl/pulse_sched.sv
// pulse_sched: programmable pulse-train scheduler.
// Generates `pulse` as a train of periods of (PERIOD+1) ticks, high for
// min(WIDTH, PERIOD) ticks at the start of each period. Runs for COUNT
// periods or continuously, optionally armed on an external PPS edge.
//
// Ports:
//   user_clk   - clock, all logic on rising edge
//   user_reset - synchronous active-high reset
//   cfg_wr     - staging register write strobe
//   cfg_addr   - 0=PERIOD, 1=WIDTH, 2=COUNT, 3=CTRL
//   cfg_wdata  - write data (CTRL: bit0 pps_arm, bit1 continuous)
//   start      - one-cycle start command (honoured in IDLE only)
//   stop       - one-cycle abort command (wins over start)
//   pps        - asynchronous PPS input
//   pulse      - registered pulse train
//   busy       - high while waiting for PPS or running
//   done       - one-cycle completion strobe
//   pulse_idx  - periods completed since last accepted start
module pulse_sched #(
  parameter int unsigned DIV = 1
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic        stop,
  input  logic        pps,
  output logic        pulse,
  output logic        busy,
  output logic        done,
  output logic [31:0] pulse_idx
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PPS = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Staging registers (software view)
  logic [DATA_W-1:0] period_q, period_d;
  logic [DATA_W-1:0] width_q, width_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [1:0]        ctrl_q, ctrl_d;

  // Active registers (used by the running schedule)
  logic [DATA_W-1:0] per_a_q, per_a_d;
  logic [DATA_W-1:0] wid_a_q, wid_a_d;
  logic [DATA_W-1:0] cnt_a_q, cnt_a_d;
  logic [1:0]        ctl_a_q, ctl_a_d;

  logic [DATA_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [PRE_W-1:0]  pre_q, pre_d;

  logic pps_s1_q, pps_s2_q, pps_s3_q;

  logic pulse_q, pulse_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic              tick_c;
  logic              pps_rise_c;
  logic [DATA_W-1:0] idx_inc_c;
  logic [DATA_W-1:0] weff_c;

  assign tick_c     = (pre_q == PRE_LAST);
  assign pps_rise_c = pps_s2_q & ~pps_s3_q;
  assign idx_inc_c  = idx_q + DATA_W'(1);

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;

  // Staging register writes, accepted in any state
  always_comb begin
    period_d = period_q;
    width_d  = width_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    if (cfg_wr) begin
      case (cfg_addr)
        ADDR_PERIOD: period_d = cfg_wdata;
        ADDR_WIDTH:  width_d  = cfg_wdata;
        ADDR_COUNT:  count_d  = cfg_wdata;
        ADDR_CTRL:   ctrl_d   = cfg_wdata[1:0];
        default:     ctrl_d   = ctrl_q;
      endcase
    end
  end

  // Next-state, schedule counters and registered outputs
  always_comb begin
    state_d = state_q;
    per_a_d = per_a_q;
    wid_a_d = wid_a_q;
    cnt_a_d = cnt_a_q;
    ctl_a_d = ctl_a_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    pre_d   = '0;
    weff_c  = '0;
    pulse_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          idx_d   = '0;
          phase_d = '0;
          per_a_d = period_q;
          wid_a_d = width_q;
          cnt_a_d = count_q;
          ctl_a_d = ctrl_q;
          if ((cnt_a_d == '0) && !ctl_a_d[1]) begin
            state_d = ST_DONE;
          end else if (ctl_a_d[0]) begin
            state_d = ST_WAIT_PPS;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_WAIT_PPS: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pps_rise_c) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
          if (tick_c) begin
            if (phase_q == per_a_q) begin
              // Period boundary: pick up staged settings for the next period
              phase_d = '0;
              idx_d   = idx_inc_c;
              per_a_d = period_q;
              wid_a_d = width_q;
              cnt_a_d = count_q;
              ctl_a_d = ctrl_q;
              if (!ctl_a_d[1] && (idx_inc_c >= cnt_a_d)) begin
                state_d = ST_DONE;
              end
            end else begin
              phase_d = phase_q + DATA_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clamping width to period guarantees a low tick at phase == PERIOD
    weff_c  = (wid_a_d < per_a_d) ? wid_a_d : per_a_d;
    pulse_d = (state_d == ST_RUN) && (phase_d < weff_c);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_WAIT_PPS);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      width_q  <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      per_a_q  <= '0;
      wid_a_q  <= '0;
      cnt_a_q  <= '0;
      ctl_a_q  <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      pre_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      width_q  <= width_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      per_a_q  <= per_a_d;
      wid_a_q  <= wid_a_d;
      cnt_a_q  <= cnt_a_d;
      ctl_a_q  <= ctl_a_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      pre_q    <= pre_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Two-flop PPS synchronizer plus one stage for rising-edge detection
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      pps_s1_q <= 1'b0;
      pps_s2_q <= 1'b0;
      pps_s3_q <= 1'b0;
    end else begin
      pps_s1_q <= pps;
      pps_s2_q <= pps_s1_q;
      pps_s3_q <= pps_s2_q;
    end
  end

endmodule

// File: doc/pulse_sched.md
PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 SHALL have parameter DIV, default 1: tick prescaler; one tick every DIV user_clk cycles (DIV=125 gives 1 us ticks at 125 MHz).
REQ-002 SHALL have port user_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-003 SHALL have port user_reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_wr, input, 1: register write strobe, accepted every cycle it is high.
REQ-005 SHALL have port cfg_addr, input, 2: 0=PERIOD, 1=WIDTH, 2=COUNT, 3=CTRL.
REQ-006 SHALL have port cfg_wdata, input, 32: write data; CTRL uses bit0 = pps_arm and bit1 = continuous.
REQ-007 SHALL have port start, input, 1: one-cycle start command.
REQ-008 SHALL have port stop, input, 1: one-cycle abort command.
REQ-009 SHALL have port pps, input, 1: asynchronous external PPS, synchronized internally with 2 flops.
REQ-010 SHALL have port pulse, output, 1: registered scheduled pulse train.
REQ-011 SHALL have port busy, output, 1: high in WAIT_PPS or RUN.
REQ-012 SHALL have port done, output, 1: one-cycle completion strobe.
REQ-013 SHALL have port pulse_idx, output, 32: number of periods completed since the last accepted start.

Function
REQ-014 SHALL hold staging registers PERIOD, WIDTH, COUNT and CTRL, written from cfg_wdata when cfg_wr=1, in any state.
REQ-015 SHALL copy staging into active registers on start acceptance and at every period boundary in RUN, so a mid-run write takes effect from the next period.
REQ-016 SHALL generate tick every DIV cycles from a prescaler that clears on start acceptance, so the first tick is DIV cycles after RUN entry.
REQ-017 SHALL define period length as P+1 ticks, tracked by a 32-bit phase counter that runs 0..P, advances on tick, and returns to 0 after P (this is the period boundary).
REQ-018 SHALL drive pulse high while in RUN and phase < Weff, where Weff = min(WIDTH, PERIOD); therefore W=0 or P=0 gives no pulse, and every period has at least one low tick.
REQ-019 SHALL implement states IDLE, WAIT_PPS, RUN and DONE.
REQ-020 SHALL, in IDLE, on start go to WAIT_PPS if pps_arm=1, else go to RUN; if COUNT=0 and continuous=0, go to DONE instead.
REQ-021 SHALL, in WAIT_PPS, go to RUN on the first synchronized pps rising edge; pps edges in other states are ignored.
REQ-022 SHALL, on RUN entry, set phase=0, and pulse SHALL be high in the first RUN cycle if Weff>0.
REQ-023 SHALL, at each period boundary, increment pulse_idx (wrapping modulo 2^32).
REQ-024 SHALL, at a period boundary with continuous=0 and incremented pulse_idx >= active COUNT, go to DONE.
REQ-025 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL, on stop in WAIT_PPS, RUN or DONE, go to IDLE next cycle with pulse=0 and no done strobe.
REQ-028 SHALL let stop win when start and stop are high in the same cycle.
REQ-029 SHALL let a COUNT write during RUN take effect at the next boundary; if the new COUNT <= pulse_idx, finish at that boundary.
REQ-030 SHALL keep pulse_idx after DONE or stop until the next accepted start, which clears it to 0.

Reset
REQ-031 SHALL, while user_reset=1 at a clock edge, set state=IDLE and pulse=0, busy=0, done=0, pulse_idx=0.
REQ-032 SHALL, on reset, clear the prescaler, phase counter and pps synchronizer, and set staging and active registers to PERIOD=0, WIDTH=0, COUNT=0, CTRL=0.
REQ-033 SHALL, on reset mid-run, force pulse low in the cycle after the reset edge.

Verification (DIV=1)
REQ-034 SHALL cover: PERIOD=9, WIDTH=3, COUNT=2, CTRL=0, start -> pulse high 3 cycles, low 7 cycles, twice; done 1 cycle later; pulse_idx=2; busy low.
REQ-035 SHALL cover: CTRL.pps_arm=1, start, pps rises 50 cycles later -> busy=1 and pulse=0 until the synchronized edge, then RUN and the first pulse.
REQ-036 SHALL cover: continuous=1, PERIOD=4, WIDTH=9, then PERIOD=7 written mid-period -> 4-high/1-low until the boundary, then 7-high/1-low; no done.
REQ-037 SHALL cover: stop during a pulse high phase -> pulse=0 and busy=0 next cycle, done never asserted, pulse_idx retained.
REQ-038 SHALL cover: COUNT=0, continuous=0, start -> done one cycle later, no pulse; also start+stop same cycle -> remains IDLE.
REQ-039 SHALL cover: user_reset mid-RUN -> all outputs 0 next cycle; a new start without reconfiguration -> immediate DONE (COUNT=0).
